jtag_uart_sys_button_pio: RTL and testbench

- Avalon-MM slave input PIO. It is the read-side counterpart of the system's LED output PIO.
- Samples external push-buttons or switches, synchronizes and debounces them, then captures edges.
- Raises a maskable level interrupt to the Nios II processor.
- Sits on the same system interconnect as the other PIOs, with zero-wait-state reads.

---
 rtl/jtag_uart_sys_button_pio_pkg.sv | 27 ++
 rtl/jtag_uart_sys_button_pio_debounce.sv | 64 ++++++
 rtl/jtag_uart_sys_button_pio.sv | 82 ++++++++
 tb/tb_jtag_uart_sys_button_pio.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/jtag_uart_sys_button_pio_pkg.sv
// Shared definitions for the button PIO: register offsets, edge encodings
// and the helper that decides whether a stable-value change counts as an edge.
package jtag_uart_sys_button_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  function automatic logic edgeFires(input int edgeType, input logic oldV, input logic newV);
    logic fires;
    fires = 1'b0;
    if (edgeType == int'(EDGE_RISE))
      fires = newV & ~oldV;
    else if (edgeType == int'(EDGE_FALL))
      fires = oldV & ~newV;
    else if (edgeType == int'(EDGE_ANY))
      fires = oldV ^ newV;
    return fires;
  endfunction

endpackage

// File: rtl/jtag_uart_sys_button_pio_debounce.sv
// One input bit: two-flop synchronizer, debounce counter, stable flop and
// a combinational edge pulse that is high in the cycle before stable updates.
module jtag_uart_sys_button_pio_debounce
  import jtag_uart_sys_button_pio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter int   EDGE_TYPE       = 0,
  parameter logic RESET_STABLE    = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit_i,
  output logic stable_o,
  output logic edge_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (DEBOUNCE_CYCLES > 0) ? CNT_W'(DEBOUNCE_CYCLES - 1) : '0;

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             update;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= RESET_STABLE;
      sync2_q  <= RESET_STABLE;
      stable_q <= RESET_STABLE;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= in_bit_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // A zero debounce length follows sync2 directly; otherwise any agreement
  // with the stable value restarts the count, so short glitches never land.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    update   = 1'b0;
    if (DEBOUNCE_CYCLES == 0) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      update   = (sync2_q != stable_q);
    end else if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      update   = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign stable_o = stable_q;
  assign edge_o   = update && edgeFires(EDGE_TYPE, stable_q, sync2_q);

endmodule

// File: rtl/jtag_uart_sys_button_pio.sv
// Avalon-MM input PIO: per-bit debounce, sticky edge capture with
// write-1-to-clear, interrupt mask and a zero-wait-state read mux.
module jtag_uart_sys_button_pio
  import jtag_uart_sys_button_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter int               EDGE_TYPE       = 0,
  parameter logic [WIDTH-1:0] RESET_STABLE    = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] edgeEvent;
  logic [WIDTH-1:0] irqMask_q, irqMask_d;
  logic [WIDTH-1:0] edgeCap_q, edgeCap_d;
  logic             wrEn;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jtag_uart_sys_button_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_TYPE      (EDGE_TYPE),
      .RESET_STABLE   (RESET_STABLE[i])
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .in_bit_i(in_port[i]),
      .stable_o(stable[i]),
      .edge_o  (edgeEvent[i])
    );
  end

  if (WIDTH < 32) begin : g_unused
    logic unusedUpperBits;
    assign unusedUpperBits = ^writedata[31:WIDTH];
  end

  assign wrEn = chipselect && !write_n;

  // A new edge is ORed in after the clear so a same-cycle set always wins.
  always_comb begin
    irqMask_d = irqMask_q;
    edgeCap_d = edgeCap_q;
    if (wrEn && address == ADDR_IRQMASK)
      irqMask_d = writedata[WIDTH-1:0];
    if (wrEn && address == ADDR_EDGECAP)
      edgeCap_d = edgeCap_q & ~writedata[WIDTH-1:0];
    edgeCap_d = edgeCap_d | edgeEvent;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqMask_q <= '0;
      edgeCap_q <= '0;
    end else begin
      irqMask_q <= irqMask_d;
      edgeCap_q <= edgeCap_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata = 32'(stable);
      ADDR_IRQMASK: readdata = 32'(irqMask_q);
      ADDR_EDGECAP: readdata = 32'(edgeCap_q);
      default:      readdata = '0;
    endcase
  end

  assign irq = |(edgeCap_q & irqMask_q);

endmodule

// File: tb/tb_jtag_uart_sys_button_pio.sv
// Directed bench: a rising-edge instance and a falling-edge instance share
// one bus and one set of button inputs.
module tb_jtag_uart_sys_button_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rdA, rdB;
  logic        irqA, irqB;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtag_uart_sys_button_pio #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .RESET_STABLE(4'b0000)
  ) dutRise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rdA),
    .in_port(in_port), .irq(irqA)
  );

  jtag_uart_sys_button_pio #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .RESET_STABLE(4'b0000)
  ) dutFall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rdB),
    .in_port(in_port), .irq(irqB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic setAddr(input logic [1:0] a);
    address = a;
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'b0000;
    tick(3);
    reset_n = 1'b1;
    tick(2);

    for (int a = 0; a < 4; a++) begin
      setAddr(a[1:0]);
      checkOutput($sformatf("reset_rd%0d", a), rdA, 32'h0);
    end
    checkOutput("reset_irq", {31'b0, irqA}, 32'h0);

    in_port = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      setAddr(2'd0);
      checkOutput($sformatf("latency_data_e%0d", k), rdA, (k >= 6) ? 32'h1 : 32'h0);
    end
    setAddr(2'd3);
    checkOutput("latency_edgecap", rdA, 32'h1);
    checkOutput("latency_irq_masked", {31'b0, irqA}, 32'h0);
    checkOutput("fall_inst_no_rise_cap", rdB, 32'h0);

    in_port = 4'b0011;
    tick(3);
    in_port = 4'b0001;
    tick(6);
    setAddr(2'd0);
    checkOutput("glitch_data", rdA, 32'h1);
    setAddr(2'd3);
    checkOutput("glitch_edgecap", rdA, 32'h1);

    in_port = 4'b0011;
    tick(8);
    setAddr(2'd0);
    checkOutput("hold_data", rdA, 32'h3);
    setAddr(2'd3);
    checkOutput("hold_edgecap", rdA, 32'h3);

    applyStimulus(2'd1, 32'hFFFF_FFF2);
    checkOutput("mask_irq_set", {31'b0, irqA}, 32'h1);
    setAddr(2'd1);
    checkOutput("mask_upper_ignored", rdA, 32'h2);
    applyStimulus(2'd3, 32'h0000_0002);
    checkOutput("w1c_irq_clear", {31'b0, irqA}, 32'h0);
    setAddr(2'd3);
    checkOutput("w1c_edgecap", rdA, 32'h1);
    applyStimulus(2'd0, 32'hFFFF_FFFF);
    setAddr(2'd0);
    checkOutput("data_write_ignored", rdA, 32'h3);
    applyStimulus(2'd2, 32'hFFFF_FFFF);
    setAddr(2'd2);
    checkOutput("reserved_reads_zero", rdA, 32'h0);
    setAddr(2'd1);
    checkOutput("reserved_write_no_alias", rdA, 32'h2);

    in_port = 4'b0111;
    tick(5);
    setAddr(2'd3);
    checkOutput("pre_collision_edgecap", rdA, 32'h1);
    applyStimulus(2'd3, 32'h0000_0004);
    setAddr(2'd3);
    checkOutput("set_wins_edgecap", rdA, 32'h5);
    setAddr(2'd0);
    checkOutput("set_wins_data", rdA, 32'h7);

    in_port = 4'b0110;
    tick(8);
    setAddr(2'd0);
    checkOutput("fall_data_rise_inst", rdA, 32'h6);
    setAddr(2'd3);
    checkOutput("fall_edgecap_rise_inst", rdA, 32'h5);
    checkOutput("fall_edgecap_fall_inst", rdB, 32'h1);
    checkOutput("fall_irq_fall_inst", {31'b0, irqB}, 32'h0);

    in_port = 4'b1110;
    tick(3);
    #2;
    reset_n = 1'b0;
    #1;
    for (int a = 0; a < 4; a++) begin
      setAddr(a[1:0]);
      checkOutput($sformatf("midreset_rd%0d", a), rdA, 32'h0);
      checkOutput($sformatf("midreset_fall_rd%0d", a), rdB, 32'h0);
    end
    checkOutput("midreset_irq", {31'b0, irqA}, 32'h0);
    in_port = 4'b0000;
    tick(2);
    reset_n = 1'b1;
    tick(10);
    setAddr(2'd0);
    checkOutput("post_reset_data", rdA, 32'h0);
    setAddr(2'd3);
    checkOutput("post_reset_edgecap", rdA, 32'h0);
    checkOutput("post_reset_fall_edgecap", rdB, 32'h0);
    checkOutput("post_reset_irq", {31'b0, irqA}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
